rot_angle_sched: RTL and testbench

Sequencer that shares one `cordic_sin_cos` core among the three rotation-matrix generators (X, Y, Z axes). It accepts per-axis angle requests and arbitrates them round-robin onto the core's phase input. In-flight axis tags are tracked in order, and each returned {sin, cos} pair is written to that axis's result registers with a completion pulse. It sits between the transform-setup logic and the rotX/rotY/rotZ matrix builders, replacing the three private CORDIC instances.

---
 rtl/rot_angle_sched.sv | 170 +++++++++++++++++
 tb/tb_rot_angle_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_angle_sched.sv
// Shares one CORDIC sin/cos core among the X/Y/Z rotation generators: round-robin issue, in-order tag return.
// Optional per-axis angle cache is compiled in with `define ROT_SCHED_ANGLE_CACHE_EN.
module rot_angle_sched #(
  parameter int CORDIC_LAT = 20,
  parameter int OUT_SHIFT  = 0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [47:0] req_angle,
  output logic [2:0]  req_ready,
  output logic        cordic_phase_tvalid,
  output logic [15:0] cordic_phase_tdata,
  input  logic        cordic_dout_tvalid,
  input  logic [31:0] cordic_dout_tdata,
  output logic [47:0] res_sin,
  output logic [47:0] res_cos,
  output logic [2:0]  res_valid,
  output logic [2:0]  done_pulse,
  output logic        busy,
  output logic        err_orphan
);

  localparam int CNT_W = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;

  typedef enum logic {S_DRAIN, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   drain_cnt;
  logic               run, found, issue, pop, orphan;
  logic [2:0]         pending, inflight, accept, hit, cand, grant, ret;
  logic [1:0]         rr_ptr, rr_nxt, gnt_idx, idx, pop_tag;
  logic [15:0]        issue_angle;
  logic [15:0]        angle_q [3];
  logic [1:0]         tag_mem [4];
  logic [2:0]         wr_ptr, rd_ptr;
  logic               fifo_empty, fifo_full;
  logic signed [15:0] dout_sin, dout_cos;
  logic [2:0][15:0]   sin_q, cos_q;

  always_ff @(posedge CLK) begin
    if (rst) state <= S_DRAIN;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_DRAIN: if (drain_cnt == CNT_W'(CORDIC_LAT - 1)) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_DRAIN;
    endcase
  end

  // The core has no reset, so results from before rst are flushed out by waiting its full latency.
  always_ff @(posedge CLK) begin
    if (rst)                   drain_cnt <= '0;
    else if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
  end

`ifdef ROT_SCHED_ANGLE_CACHE_EN
  logic [15:0] cache_angle [3];
  logic [2:0]  cache_vld;

  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++)
      hit[i] = accept[i] & cache_vld[i] & (req_angle[16*i +: 16] == cache_angle[i]);
  end

  always_ff @(posedge CLK) begin
    if (rst) cache_vld <= '0;
    else     cache_vld <= cache_vld | ret;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++)
      if (ret[i]) cache_angle[i] <= angle_q[i];
  end
`else
  assign hit = '0;
`endif

  always_comb begin
    run        = (state == S_RUN);
    req_ready  = {3{run}} & ~pending & ~inflight;
    accept     = req_valid & req_ready;
    cand       = pending | (accept & ~hit);
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[2] != rd_ptr[2]) && (wr_ptr[1:0] == rd_ptr[1:0]);

    // Round-robin: first candidate at or after rr_ptr. A full tag FIFO blocks issue outright.
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < 3; k++) begin
      idx = 2'((int'(rr_ptr) + k) % 3);
      if (!found && cand[idx] && !fifo_full) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = idx;
      end
    end
    issue  = found;
    rr_nxt = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;

    issue_angle = '0;
    for (int i = 0; i < 3; i++)
      if (grant[i]) issue_angle = accept[i] ? req_angle[16*i +: 16] : angle_q[i];

    pop     = run & cordic_dout_tvalid & ~fifo_empty;
    orphan  = run & cordic_dout_tvalid & fifo_empty;
    pop_tag = tag_mem[rd_ptr[1:0]];
    ret     = pop ? (3'b001 << pop_tag) : 3'b000;
  end

  assign dout_sin = $signed(cordic_dout_tdata[31:16]) >>> OUT_SHIFT;
  assign dout_cos = $signed(cordic_dout_tdata[15:0]) >>> OUT_SHIFT;

  // NOTE: angle and tag storage are qualified by valid/pointer state, so they carry no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++)
      if (accept[i]) angle_q[i] <= req_angle[16*i +: 16];
    if (issue) tag_mem[wr_ptr[1:0]] <= gnt_idx;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (rst) begin
      pending             <= '0;
      inflight            <= '0;
      rr_ptr              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      cordic_phase_tvalid <= 1'b0;
      cordic_phase_tdata  <= '0;
      sin_q               <= '0;
      cos_q               <= '0;
      res_valid           <= '0;
      done_pulse          <= '0;
      err_orphan          <= 1'b0;
    end else begin
      pending             <= cand & ~grant;
      inflight            <= (inflight | grant) & ~ret;
      cordic_phase_tvalid <= issue;
      if (issue) begin
        cordic_phase_tdata <= issue_angle;
        rr_ptr             <= rr_nxt;
      end
      wr_ptr     <= wr_ptr + {2'b00, issue};
      rd_ptr     <= rd_ptr + {2'b00, pop};
      res_valid  <= (res_valid & ~accept) | ret | hit;
      done_pulse <= ret | hit;
      for (int i = 0; i < 3; i++) begin
        if (ret[i]) begin
          sin_q[i] <= dout_sin;
          cos_q[i] <= dout_cos;
        end
      end
      err_orphan <= err_orphan | orphan;
    end
  end

  assign res_sin = sin_q;
  assign res_cos = cos_q;
  assign busy    = (state == S_DRAIN) | (|pending) | (|inflight);

endmodule

// File: tb/tb_rot_angle_sched.sv
// Self-checking bench for rot_angle_sched: behavioural CORDIC stand-in, vector table, and issue/result scoreboards.
// Stand-in core returns sin = phase, cos = 16'h4000 - phase after CORDIC_LAT cycles.
module tb_rot_angle_sched;

  localparam int CORDIC_LAT = 20;
  localparam int OUT_SHIFT  = 9;

  logic        CLK = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [47:0] req_angle;
  logic [2:0]  req_ready;
  logic        cordic_phase_tvalid;
  logic [15:0] cordic_phase_tdata;
  logic        cordic_dout_tvalid;
  logic [31:0] cordic_dout_tdata;
  logic [47:0] res_sin, res_cos;
  logic [2:0]  res_valid, done_pulse;
  logic        busy, err_orphan;

  rot_angle_sched #(.CORDIC_LAT(CORDIC_LAT), .OUT_SHIFT(OUT_SHIFT)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .cordic_phase_tvalid(cordic_phase_tvalid), .cordic_phase_tdata(cordic_phase_tdata),
    .cordic_dout_tvalid(cordic_dout_tvalid), .cordic_dout_tdata(cordic_dout_tdata),
    .res_sin(res_sin), .res_cos(res_cos), .res_valid(res_valid),
    .done_pulse(done_pulse), .busy(busy), .err_orphan(err_orphan)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Core stand-in: fixed-latency pipe with no reset, plus a direct injection path.
  logic [CORDIC_LAT-1:0] pipe_v = '0;
  logic [15:0]           pipe_a [CORDIC_LAT];
  logic                  inj_v;
  logic [31:0]           inj_data;

  always @(posedge CLK) begin
    pipe_v    <= {pipe_v[CORDIC_LAT-2:0], cordic_phase_tvalid};
    pipe_a[0] <= cordic_phase_tdata;
    for (int i = 1; i < CORDIC_LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign cordic_dout_tvalid = pipe_v[CORDIC_LAT-1] | inj_v;
  assign cordic_dout_tdata  = inj_v ? inj_data :
                              pipe_v[CORDIC_LAT-1] ? {pipe_a[CORDIC_LAT-1], 16'h4000 - pipe_a[CORDIC_LAT-1]} :
                              32'h0;

  typedef struct {
    logic [1:0]  axis;
    logic [15:0] angle;
    logic [15:0] exp_sin;
    logic [15:0] exp_cos;
  } vec_t;

  typedef struct { logic [15:0] angle; int due; } iss_exp_t;
  typedef struct { logic [1:0] axis; logic [15:0] s; logic [15:0] c; int due; } res_exp_t;

  vec_t     vecs [6];
  iss_exp_t iq [$];
  res_exp_t rq [$];
  iss_exp_t mon_s;
  res_exp_t mon_r;

  logic [15:0] m_sin [3];
  logic [15:0] m_cos [3];
  logic [2:0]  m_valid;
  logic [15:0] ang [3];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Issue and result monitors, sampled on the falling edge.
  always @(negedge CLK) begin
    if (dut.fifo_full) begin
      failures++;
      $display("FAIL tag_fifo_full: got full=1 expected full=0 (cycle %0d)", cyc);
    end
    if (cordic_phase_tvalid) begin
      if (iq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue: got angle=%0h expected no issue (cycle %0d)", cordic_phase_tdata, cyc);
      end else begin
        mon_s = iq.pop_front();
        check("issue_angle", cordic_phase_tdata, mon_s.angle);
        check("issue_cycle", cyc, mon_s.due);
      end
    end
    if (done_pulse != 3'b000) begin
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done_pulse=%b expected 000 (cycle %0d)", done_pulse, cyc);
      end else begin
        mon_r = rq.pop_front();
        check("done_pulse", done_pulse, 3'b001 << mon_r.axis);
        check("done_cycle", cyc, mon_r.due);
        check("res_sin", res_sin[16*mon_r.axis +: 16], mon_r.s);
        check("res_cos", res_cos[16*mon_r.axis +: 16], mon_r.c);
        check("res_valid_bit", res_valid[mon_r.axis], 1'b1);
        m_sin[mon_r.axis]   = mon_r.s;
        m_cos[mon_r.axis]   = mon_r.c;
        m_valid[mon_r.axis] = 1'b1;
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_sin[i] = '0;
      m_cos[i] = '0;
    end
    m_valid = '0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_sin"}, res_sin[16*i +: 16], m_sin[i]);
      check({tag, "_cos"}, res_cos[16*i +: 16], m_cos[i]);
    end
    check({tag, "_valid"}, res_valid, m_valid);
  endtask

  // Called on the accept cycle; iss_off is the issue slot the request should get.
  task automatic expect_op(input int ax, input int vi, input int iss_off, input bit issued);
    iss_exp_t s;
    res_exp_t r;
    m_valid[ax] = 1'b0;
    if (issued) begin
      s.angle = vecs[vi].angle;
      s.due   = cyc + iss_off;
      iq.push_back(s);
      r.due   = cyc + iss_off + CORDIC_LAT + 1;
    end else begin
      r.due   = cyc + 1;
    end
    r.axis = 2'(ax);
    r.s    = vecs[vi].exp_sin;
    r.c    = vecs[vi].exp_cos;
    rq.push_back(r);
  endtask

  task automatic drive(input logic [2:0] mask, input logic [15:0] ax_x, input logic [15:0] ax_y,
                       input logic [15:0] ax_z);
    req_angle = {ax_z, ax_y, ax_x};
    req_valid = mask;
    check("req_ready_at_accept", req_ready & mask, mask);
    @(negedge CLK);
    req_valid = '0;
  endtask

  task automatic wait_ready(input int ax);
    int n = 0;
    while (!req_ready[ax] && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready[ax]) begin
      failures++;
      $display("FAIL wait_ready_timeout: got req_ready=%b expected bit %0d set", req_ready, ax);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((iq.size() != 0 || rq.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (iq.size() != 0 || rq.size() != 0) begin
      failures++;
      $display("FAIL wait_idle_timeout: got %0d issues and %0d results outstanding expected 0",
               iq.size(), rq.size());
      iq.delete();
      rq.delete();
    end
    @(negedge CLK);
  endtask

  task automatic drain_phase(input bit inject);
    for (int i = 0; i < CORDIC_LAT; i++) begin
      check("drain_req_ready", req_ready, 3'b000);
      check("drain_busy", busy, 1'b1);
      inj_v    = inject && (i == 4);
      inj_data = 32'h1234_5678;
      @(negedge CLK);
    end
    inj_v = 1'b0;
    check("run_req_ready", req_ready, 3'b111);
    check("run_err_orphan", err_orphan, 1'b0);
  endtask

  initial begin
    vecs[0] = '{2'd1, 16'h0000, 16'h0000, 16'h0020};
    vecs[1] = '{2'd0, 16'h1922, 16'h000C, 16'h0013};
    vecs[2] = '{2'd2, 16'hE6DE, 16'hFFF3, 16'h002C};
    vecs[3] = '{2'd0, 16'h8000, 16'hFFC0, 16'hFFE0};
    vecs[4] = '{2'd1, 16'h7FFF, 16'h003F, 16'hFFE0};
    vecs[5] = '{2'd2, 16'h0200, 16'h0001, 16'h001F};

    rst       = 1'b1;
    req_valid = '0;
    req_angle = '0;
    inj_v     = 1'b0;
    inj_data  = '0;
    model_clear();

    // Reset values, then drain with a stale core result injected mid-way.
    repeat (2) @(negedge CLK);
    check("rst_res_valid", res_valid, 3'b000);
    check("rst_res_sin", res_sin, 48'h0);
    check("rst_res_cos", res_cos, 48'h0);
    check("rst_done", done_pulse, 3'b000);
    check("rst_phase_tvalid", cordic_phase_tvalid, 1'b0);
    check("rst_phase_tdata", cordic_phase_tdata, 16'h0);
    check("rst_err_orphan", err_orphan, 1'b0);
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_busy", busy, 1'b1);
    rst = 1'b0;
    drain_phase(1'b1);
    check("idle_busy", busy, 1'b0);

    // Single uncontended requests across axes and angle corners.
    for (int v = 0; v < 6; v++) begin
      wait_ready(vecs[v].axis);
      for (int i = 0; i < 3; i++) ang[i] = '0;
      ang[vecs[v].axis] = vecs[v].angle;
      expect_op(vecs[v].axis, v, 1, 1'b1);
      drive(3'b001 << vecs[v].axis, ang[0], ang[1], ang[2]);
      check("accept_clears_valid", res_valid[vecs[v].axis], 1'b0);
      check("accept_busy", busy, 1'b1);
      wait_idle();
    end
    check_regs("after_vectors");

    // Contention with pointer at X: X, Y, Z on consecutive cycles.
    expect_op(0, 0, 1, 1'b1);
    expect_op(1, 1, 2, 1'b1);
    expect_op(2, 2, 3, 1'b1);
    drive(3'b111, vecs[0].angle, vecs[1].angle, vecs[2].angle);
    wait_idle();

    // Lone X moves the pointer to Y, so the next contention goes Y, Z, X.
    expect_op(0, 3, 1, 1'b1);
    drive(3'b001, vecs[3].angle, 16'h0, 16'h0);
    wait_idle();
    expect_op(1, 4, 1, 1'b1);
    expect_op(2, 3, 2, 1'b1);
    expect_op(0, 5, 3, 1'b1);
    drive(3'b111, vecs[5].angle, vecs[4].angle, vecs[3].angle);
    wait_idle();
    check_regs("after_contention");
    check("contention_busy", busy, 1'b0);

    // Orphan return in RUN: sticky error, results untouched.
    inj_v    = 1'b1;
    inj_data = 32'hDEAD_BEEF;
    @(negedge CLK);
    inj_v = 1'b0;
    check("orphan_set", err_orphan, 1'b1);
    check_regs("orphan");
    repeat (3) @(negedge CLK);
    check("orphan_sticky", err_orphan, 1'b1);

    // Reset while Z is in flight; its late result lands during DRAIN.
    wait_ready(2);
    expect_op(2, 5, 1, 1'b1);
    drive(3'b100, 16'h0, 16'h0, vecs[5].angle);
    repeat (4) @(negedge CLK);
    check("inflight_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    iq.delete();
    rq.delete();
    model_clear();
    drain_phase(1'b0);
    check("midrst_res_valid", res_valid, 3'b000);
    check("midrst_res_sin", res_sin, 48'h0);
    check("midrst_res_cos", res_cos, 48'h0);
    repeat (5) @(negedge CLK);
    check("midrst_err_orphan", err_orphan, 1'b0);
    check("midrst_busy", busy, 1'b0);

    // Repeat of the same X angle: cache hit when compiled in, otherwise a normal issue.
    expect_op(0, 1, 1, 1'b1);
    drive(3'b001, vecs[1].angle, 16'h0, 16'h0);
    wait_idle();
`ifdef ROT_SCHED_ANGLE_CACHE_EN
    expect_op(0, 1, 1, 1'b0);
`else
    expect_op(0, 1, 1, 1'b1);
`endif
    drive(3'b001, vecs[1].angle, 16'h0, 16'h0);
    wait_idle();
    expect_op(0, 5, 1, 1'b1);
    drive(3'b001, vecs[5].angle, 16'h0, 16'h0);
    wait_idle();
    check_regs("after_cache");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
